multicycle_control_fsm: RTL and testbench

- Multi-cycle sequencer for the MIPS-style datapath. Replaces the single-cycle opcode decoder with a state machine that steps each instruction through fetch, decode, execute, memory and writeback phases over successive clocks.
- Drives the existing datapath control signals (reg_dst, branch, mem_to_reg, mem_write, alu_op, alu_src, reg_write, jump, byte_op, move) plus PC, IR and memory-handshake enables.
- Stalls on a shared instruction/data memory via mem_ready.

---
 rtl/multicycle_control_fsm.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS-style control sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath control lines.
module multicycle_control_fsm #(
  parameter int unsigned OPC_W   = 6,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic               branch,
  output logic               jump,
  output logic               byte_op,
  output logic               move,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    EXEC   = STATE_W'(2),
    MEM    = STATE_W'(3),
    WB     = STATE_W'(4),
    BRANCH = STATE_W'(5),
    JUMP   = STATE_W'(6),
    TRAP   = STATE_W'(7)
  } state_t;

  localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_LB   = OPC_W'(6'b100000);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OP_SB   = OPC_W'(6'b101000);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'b000010);
  localparam logic [OPC_W-1:0] OP_MOVE = OPC_W'(6'b010000);

  state_t           state_q;
  logic [OPC_W-1:0] opc_q;
  logic             illegal_q;

  logic is_r, is_lw, is_lb, is_sw, is_sb, is_move, is_load, is_store;

  function automatic state_t decode_next(input logic [OPC_W-1:0] o);
    case (o)
      OP_R, OP_LW, OP_LB, OP_SW, OP_SB, OP_ADDI, OP_MOVE: decode_next = EXEC;
      OP_BEQ:  decode_next = BRANCH;
      OP_J:    decode_next = JUMP;
      default: decode_next = TRAP;
    endcase
  endfunction

  // Post-decode states classify from the latched opcode, never the live input.
  always_comb begin
    is_r     = (opc_q == OP_R);
    is_lw    = (opc_q == OP_LW);
    is_lb    = (opc_q == OP_LB);
    is_sw    = (opc_q == OP_SW);
    is_sb    = (opc_q == OP_SB);
    is_move  = (opc_q == OP_MOVE);
    is_load  = is_lw | is_lb;
    is_store = is_sw | is_sb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      opc_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH:  if (en && mem_ready) state_q <= DECODE;
        DECODE: begin
          opc_q   <= opcode;
          state_q <= decode_next(opcode);
          if (decode_next(opcode) == TRAP) illegal_q <= 1'b1;
        end
        EXEC:   state_q <= (is_load || is_store) ? MEM : WB;
        MEM:    if (mem_ready) state_q <= is_store ? FETCH : WB;
        WB, BRANCH, JUMP: state_q <= FETCH;
        TRAP:   state_q <= TRAP;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Outputs decode combinationally from the state register because memory
  // handshakes and the branch PC load must react to mem_ready/zero in-cycle;
  // rst masks them so an aborted instruction writes nothing on that cycle.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    branch     = 1'b0;
    jump       = 1'b0;
    byte_op    = 1'b0;
    move       = 1'b0;
    instr_done = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: if (en) begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        DECODE: alu_src_b = 2'b11;
        EXEC: begin
          alu_src_a = 1'b1;
          if (is_r)         alu_op    = 3'b010;
          else if (is_move) move      = 1'b1;
          else              alu_src_b = 2'b10;
        end
        MEM: begin
          i_or_d     = 1'b1;
          byte_op    = is_lb | is_sb;
          mem_read   = is_load;
          mem_write  = is_store;
          instr_done = is_store & mem_ready;
        end
        WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          reg_dst    = is_r | is_move;
          mem_to_reg = is_load;
          move       = is_move;
          byte_op    = is_lb;
        end
        BRANCH: begin
          branch     = 1'b1;
          alu_src_a  = 1'b1;
          alu_op     = 3'b001;
          pc_src     = 2'b01;
          pc_write   = zero;
          instr_done = 1'b1;
        end
        JUMP: begin
          jump       = 1'b1;
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    illegal = illegal_q & ~rst;
    state   = rst ? '0 : state_q;
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed vector table, hand-written corner
// sequences, and random instruction streams checked against a trace model.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst, en, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, branch, jump, byte_op, move;
  logic       instr_done, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.OPC_W(6), .STATE_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .branch(branch), .jump(jump), .byte_op(byte_op),
    .move(move), .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       branch;
    logic       jump;
    logic       byte_op;
    logic       move;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    logic       en;
    logic       mr;
    logic [5:0] opc;
    logic       zero;
    ctl_t       exp;
  } cyc_t;

  typedef struct {
    logic [5:0]  opc;
    logic        z;
    int unsigned len;
    logic [47:0] states;
    int unsigned rw, mw, pcw, done;
  } tv_t;

  cyc_t q[$];
  tv_t  tbl[10];
  int   n_chk = 0;
  int   n_fail = 0;

  localparam logic [5:0] LEGAL [9] = '{6'h00, 6'h23, 6'h20, 6'h2b, 6'h28,
                                       6'h08, 6'h04, 6'h02, 6'h10};

  function automatic ctl_t observed();
    ctl_t o;
    o.st = state; o.pc_write = pc_write; o.pc_src = pc_src;
    o.ir_write = ir_write; o.i_or_d = i_or_d; o.mem_read = mem_read;
    o.mem_write = mem_write; o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg;
    o.reg_write = reg_write; o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b;
    o.alu_op = alu_op; o.branch = branch; o.jump = jump; o.byte_op = byte_op;
    o.move = move; o.instr_done = instr_done; o.illegal = illegal;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_glitch();
    logic bad;
    bad = (mem_write && reg_write) || (mem_write && state != 4'd3) ||
          (reg_write && state != 4'd4);
    check("glitch", 64'(bad), 64'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input ctl_t e, input logic mr, input logic [5:0] o,
                      input logic z, input logic en_v);
    cyc_t c;
    c.en = en_v; c.mr = mr; c.opc = o; c.zero = z; c.exp = e;
    q.push_back(c);
  endtask

  // Trace model: one record per expected cycle of an instruction, with the
  // mem_ready/opcode stimulus for that cycle.
  task automatic build(input logic [5:0] o, input logic z,
                       input int unsigned fw, input int unsigned mw);
    ctl_t e;
    logic ld, sto, bop, rt, mv;
    ld  = (o == 6'h23) || (o == 6'h20);
    sto = (o == 6'h2b) || (o == 6'h28);
    bop = (o == 6'h20) || (o == 6'h28);
    rt  = (o == 6'h00);
    mv  = (o == 6'h10);
    e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01;
    for (int unsigned i = 0; i < fw; i++)
      push(e, 1'b0, 6'($urandom), 1'($urandom), 1'b1);
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(e, 1'b1, 6'($urandom), 1'($urandom), 1'b1);
    e = '0; e.st = 4'd1; e.alu_src_b = 2'b11;
    push(e, 1'($urandom), o, 1'($urandom), 1'b1);
    if (o == 6'h04) begin
      e = '0; e.st = 4'd5; e.branch = 1'b1; e.alu_src_a = 1'b1; e.alu_op = 3'b001;
      e.pc_src = 2'b01; e.pc_write = z; e.instr_done = 1'b1;
      push(e, 1'($urandom), 6'($urandom), z, 1'b1);
    end else if (o == 6'h02) begin
      e = '0; e.st = 4'd6; e.jump = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b10;
      e.instr_done = 1'b1;
      push(e, 1'($urandom), 6'($urandom), 1'($urandom), 1'b1);
    end else begin
      e = '0; e.st = 4'd2; e.alu_src_a = 1'b1;
      if (rt)      e.alu_op = 3'b010;
      else if (mv) e.move = 1'b1;
      else         e.alu_src_b = 2'b10;
      push(e, 1'($urandom), 6'($urandom), 1'($urandom), 1'b1);
      if (ld || sto) begin
        e = '0; e.st = 4'd3; e.i_or_d = 1'b1; e.mem_read = ld; e.mem_write = sto;
        e.byte_op = bop;
        for (int unsigned i = 0; i < mw; i++)
          push(e, 1'b0, 6'($urandom), 1'($urandom), 1'b1);
        e.instr_done = sto;
        push(e, 1'b1, 6'($urandom), 1'($urandom), 1'b1);
      end
      if (!sto) begin
        e = '0; e.st = 4'd4; e.reg_write = 1'b1; e.instr_done = 1'b1;
        e.mem_to_reg = ld; e.reg_dst = rt || mv; e.move = mv; e.byte_op = (o == 6'h20);
        push(e, 1'($urandom), 6'($urandom), 1'($urandom), 1'b1);
      end
    end
  endtask

  task automatic run_queue(input string tag);
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      en = c.en; mem_ready = c.mr; opcode = c.opc; zero = c.zero;
      @(negedge clk);
      check(tag, 64'(observed()), 64'(c.exp));
      check_glitch();
      next_cycle();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t        e;
    logic [47:0] sv;
    logic [3:0]  s, nx;
    int unsigned rw, mw, pcw, dn;

    //            opc     z     len states     rw mw pcw done
    tbl[0] = '{6'h00, 1'b0, 4, 48'h4210,    1, 0, 1, 1};  // R-type
    tbl[1] = '{6'h23, 1'b0, 7, 48'h4333210, 1, 0, 1, 1};  // lw, 2 mem waits
    tbl[2] = '{6'h28, 1'b0, 4, 48'h3210,    0, 1, 1, 1};  // sb
    tbl[3] = '{6'h04, 1'b1, 3, 48'h510,     0, 0, 2, 1};  // beq taken
    tbl[4] = '{6'h04, 1'b0, 3, 48'h510,     0, 0, 1, 1};  // beq not taken
    tbl[5] = '{6'h02, 1'b0, 3, 48'h610,     0, 0, 2, 1};  // j
    tbl[6] = '{6'h08, 1'b0, 5, 48'h42100,   1, 0, 1, 1};  // addi, 1 fetch wait
    tbl[7] = '{6'h10, 1'b0, 4, 48'h4210,    1, 0, 1, 1};  // move
    tbl[8] = '{6'h2b, 1'b0, 5, 48'h33210,   0, 2, 1, 1};  // sw, 1 mem wait
    tbl[9] = '{6'h20, 1'b0, 5, 48'h43210,   1, 0, 1, 1};  // lb

    rst = 1'b1; en = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = 6'h23;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_outputs", 64'(observed()), 64'd0);
      next_cycle();
    end
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
    check("post_reset", 64'(observed()), 64'd0);
    next_cycle();

    for (int i = 0; i < 10; i++) begin
      rw = 0; mw = 0; pcw = 0; dn = 0;
      sv = tbl[i].states;
      for (int unsigned k = 0; k < tbl[i].len; k++) begin
        s  = sv[4*k +: 4];
        nx = (k + 1 < tbl[i].len) ? sv[4*(k+1) +: 4] : 4'hF;
        en = 1'b1; opcode = tbl[i].opc; zero = tbl[i].z;
        mem_ready = (s == nx) ? 1'b0 : 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d_state%0d", i, k), 64'(state), 64'(s));
        if (s == 4'd3)
          check($sformatf("vec%0d_memreq%0d", i, k),
                64'({mem_read, mem_write, i_or_d, byte_op}),
                64'({tbl[i].mw == 0, tbl[i].mw != 0, 1'b1,
                     tbl[i].opc == 6'h20 || tbl[i].opc == 6'h28}));
        check_glitch();
        rw += 32'(reg_write); mw += 32'(mem_write);
        pcw += 32'(pc_write); dn += 32'(instr_done);
        next_cycle();
      end
      en = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_return", i), 64'(state), 64'd0);
      check($sformatf("vec%0d_reg_write_cycles", i), 64'(rw), 64'(tbl[i].rw));
      check($sformatf("vec%0d_mem_write_cycles", i), 64'(mw), 64'(tbl[i].mw));
      check($sformatf("vec%0d_pc_write_cycles", i), 64'(pcw), 64'(tbl[i].pcw));
      check($sformatf("vec%0d_done_pulses", i), 64'(dn), 64'(tbl[i].done));
      next_cycle();
    end

    // Illegal opcode: sticky TRAP until reset.
    en = 1'b1; mem_ready = 1'b1; opcode = 6'b111000;
    @(negedge clk); check("trap_fetch", 64'(state), 64'd0); next_cycle();
    @(negedge clk); check("trap_decode", 64'(state), 64'd1); next_cycle();
    e = '0; e.st = 4'd7; e.illegal = 1'b1;
    for (int i = 0; i < 12; i++) begin
      en = 1'($urandom); mem_ready = 1'($urandom); zero = 1'($urandom);
      opcode = 6'($urandom);
      @(negedge clk);
      check("trap_hold", 64'(observed()), 64'(e));
      next_cycle();
    end
    rst = 1'b1; next_cycle();
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
    check("trap_cleared", 64'(observed()), 64'd0);
    next_cycle();

    // Reset while a sw is waiting in MEM.
    en = 1'b1; mem_ready = 1'b1; opcode = 6'h2b;
    next_cycle(); next_cycle(); next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    check("sw_in_mem", 64'({state, mem_write}), 64'({4'd3, 1'b1}));
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
    check("sw_aborted", 64'({state, mem_write}), 64'd0);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      mem_ready = 1'($urandom); opcode = 6'($urandom);
      @(negedge clk);
      check("en_low_hold", 64'(observed()), 64'd0);
    end
    next_cycle();

    // Random instruction stream with idle gaps.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        e = '0;
        push(e, 1'($urandom), 6'($urandom), 1'($urandom), 1'b0);
      end
      build(LEGAL[$urandom_range(0, 8)], 1'($urandom),
            $urandom_range(0, 2), $urandom_range(0, 3));
      run_queue("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
